// File: rtl/ysyx_2022040010_cache_data_array_pkg.sv
// Shared parameters and FSM encoding for the cache data array and its RAM.
package ysyx_2022040010_cache_data_array_pkg;

  localparam int unsigned DATA_W_DEF     = 64;
  localparam int unsigned IDX_W_DEF      = 6;
  localparam int unsigned OFF_W_DEF      = 1;
  localparam int unsigned STRB_W_DEF     = DATA_W_DEF / 8;
  localparam int unsigned DEPTH_DEF      = 2 ** IDX_W_DEF;
  localparam int unsigned LINE_BEATS_DEF = 2 ** OFF_W_DEF;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_e;

endpackage

// File: rtl/ysyx_2022040010_cache_data_ram.sv
// Word storage with byte-masked synchronous write and a registered read port.
module ysyx_2022040010_cache_data_ram #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ADDR_W = 7
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we_i,
  input  logic                  rd_en_i,
  input  logic [ADDR_W-1:0]     addr_i,
  input  logic [DATA_W-1:0]     wdata_i,
  input  logic [DATA_W/8-1:0]   wstrb_i,
  output logic [DATA_W-1:0]     rdata_o
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned DEPTH  = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mask;
  logic [DATA_W-1:0] merged;
  logic [DATA_W-1:0] rdata_d, rdata_q;

  // A read is a merge with an all-zero strobe, so one path serves reads and writes.
  always_comb begin
    mask = '0;
    for (int unsigned b = 0; b < STRB_W; b++) begin
      mask[b*8 +: 8] = {8{wstrb_i[b]}};
    end
    merged  = (mem_q[addr_i] & ~mask) | (wdata_i & mask);
    rdata_d = rd_en_i ? merged : rdata_q;
  end

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= merged;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/ysyx_2022040010_cache_data_array.sv
// Cache data array: CPU read/write port plus a burst refill port with beat FSM.
module ysyx_2022040010_cache_data_array
  import ysyx_2022040010_cache_data_array_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned IDX_W  = IDX_W_DEF,
  parameter int unsigned OFF_W  = OFF_W_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [IDX_W-1:0]    req_idx,
  input  logic [OFF_W-1:0]    req_off,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_wstrb,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  input  logic                fill_valid,
  output logic                fill_ready,
  input  logic [IDX_W-1:0]    fill_idx,
  input  logic [DATA_W-1:0]   fill_data,
  input  logic                fill_last,
  output logic                fill_done,
  output logic                fill_err
);

  localparam int unsigned LINE_BEATS = 2 ** OFF_W;
  localparam int unsigned ADDR_W     = IDX_W + OFF_W;

  state_e             state_d, state_q;
  logic [OFF_W-1:0]   cnt_d, cnt_q;
  logic [IDX_W-1:0]   idx_d, idx_q;
  logic               err_d, err_q;
  logic               done_d, done_q;
  logic               rsp_valid_d, rsp_valid_q;

  logic [OFF_W-1:0]    fill_off;
  logic [IDX_W-1:0]    fill_line;
  logic                fill_at_end;
  logic                ram_we, ram_rd;
  logic [ADDR_W-1:0]   ram_addr;
  logic [DATA_W-1:0]   ram_wdata;
  logic [DATA_W/8-1:0] ram_wstrb;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    err_d       = err_q;
    done_d      = 1'b0;
    rsp_valid_d = 1'b0;
    req_ready   = 1'b0;
    fill_ready  = 1'b1;
    ram_we      = 1'b0;
    ram_rd      = 1'b0;
    ram_addr    = {req_idx, req_off};
    ram_wdata   = req_wdata;
    ram_wstrb   = req_we ? req_wstrb : '0;

    // First beat comes from IDLE using the live index at offset 0.
    fill_off    = (state_q == FILL) ? cnt_q : '0;
    fill_line   = (state_q == FILL) ? idx_q : fill_idx;
    fill_at_end = (fill_off == OFF_W'(LINE_BEATS - 1));

    if (fill_valid) begin
      ram_we    = 1'b1;
      ram_addr  = {fill_line, fill_off};
      ram_wdata = fill_data;
      ram_wstrb = '1;
      if (fill_last != fill_at_end) begin
        err_d = 1'b1;
      end
      if (fill_at_end) begin
        state_d = IDLE;
        cnt_d   = '0;
        done_d  = 1'b1;
      end else begin
        state_d = FILL;
        cnt_d   = fill_off + OFF_W'(1);
        idx_d   = fill_line;
      end
    end else if (state_q == IDLE) begin
      req_ready = 1'b1;
      if (req_valid) begin
        ram_we      = req_we;
        ram_rd      = 1'b1;
        rsp_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      err_q       <= err_d;
      done_q      <= done_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  ysyx_2022040010_cache_data_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (ram_we),
    .rd_en_i (ram_rd),
    .addr_i  (ram_addr),
    .wdata_i (ram_wdata),
    .wstrb_i (ram_wstrb),
    .rdata_o (rsp_rdata)
  );

  assign rsp_valid = rsp_valid_q;
  assign fill_done = done_q;
  assign fill_err  = err_q;

endmodule

// File: tb/tb_ysyx_2022040010_cache_data_array.sv
// Directed bench with a line-level behavioural model checked every cycle.
module tb_ysyx_2022040010_cache_data_array;

  localparam int DATA_W = 64;
  localparam int IDX_W  = 6;
  localparam int OFF_W  = 1;
  localparam int LB     = 2 ** OFF_W;
  localparam int WORDS  = (2 ** IDX_W) * LB;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                req_valid = 1'b0;
  logic                req_ready;
  logic                req_we = 1'b0;
  logic [IDX_W-1:0]    req_idx = '0;
  logic [OFF_W-1:0]    req_off = '0;
  logic [DATA_W-1:0]   req_wdata = '0;
  logic [DATA_W/8-1:0] req_wstrb = '0;
  logic                rsp_valid;
  logic [DATA_W-1:0]   rsp_rdata;
  logic                fill_valid = 1'b0;
  logic                fill_ready;
  logic [IDX_W-1:0]    fill_idx = '0;
  logic [DATA_W-1:0]   fill_data = '0;
  logic                fill_last = 1'b0;
  logic                fill_done;
  logic                fill_err;

  int n_checks = 0;
  int n_errors = 0;

  ysyx_2022040010_cache_data_array #(
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W),
    .OFF_W  (OFF_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_idx    (req_idx),
    .req_off    (req_off),
    .req_wdata  (req_wdata),
    .req_wstrb  (req_wstrb),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .fill_valid (fill_valid),
    .fill_ready (fill_ready),
    .fill_idx   (fill_idx),
    .fill_data  (fill_data),
    .fill_last  (fill_last),
    .fill_done  (fill_done),
    .fill_err   (fill_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a flat word array, plus how many beats of the current line have arrived.
  logic [63:0] m_mem [WORDS];
  logic        m_busy;
  int          m_beat;
  int          m_line;
  logic        e_rv, e_done, e_err;
  logic [63:0] e_rdata;

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] nw,
                                        input logic [7:0] st);
    logic [63:0] r;
    r = old;
    for (int b = 0; b < 8; b++) if (st[b]) r[b*8 +: 8] = nw[b*8 +: 8];
    return r;
  endfunction

  int          f_line, f_k, f_addr, r_addr;
  logic [63:0] r_word;
  always_comb begin
    f_line = m_busy ? m_line : int'(fill_idx);
    f_k    = m_busy ? m_beat : 0;
    f_addr = f_line * LB + f_k;
    r_addr = int'(req_idx) * LB + int'(req_off);
    r_word = merge(m_mem[r_addr], req_wdata, req_we ? req_wstrb : 8'h00);
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_beat <= 0; m_line <= 0;
      e_rv <= 1'b0; e_done <= 1'b0; e_err <= 1'b0; e_rdata <= '0;
    end else begin
      e_rv   <= 1'b0;
      e_done <= 1'b0;
      if (fill_valid) begin
        m_mem[f_addr] <= fill_data;
        if (fill_last != (f_k == LB - 1)) e_err <= 1'b1;
        if (f_k == LB - 1) begin
          m_busy <= 1'b0; m_beat <= 0; e_done <= 1'b1;
        end else begin
          m_busy <= 1'b1; m_beat <= f_k + 1; m_line <= f_line;
        end
      end else if (req_valid && !m_busy) begin
        m_mem[r_addr] <= r_word;
        e_rdata <= r_word;
        e_rv    <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    chk("req_ready", {63'd0, req_ready}, {63'd0, !m_busy && !fill_valid});
    chk("fill_ready", {63'd0, fill_ready}, 64'd1);
    chk("rsp_valid", {63'd0, rsp_valid}, {63'd0, e_rv});
    chk("rsp_rdata", rsp_rdata, e_rdata);
    chk("fill_done", {63'd0, fill_done}, {63'd0, e_done});
    chk("fill_err", {63'd0, fill_err}, {63'd0, e_err});
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic beat(input int idx, input logic [63:0] d, input logic last);
    fill_valid = 1'b1; fill_idx = IDX_W'(idx); fill_data = d; fill_last = last;
    cyc();
    fill_valid = 1'b0; fill_last = 1'b0;
  endtask

  // Present a request and hold it until accepted; returns just after the accepting edge.
  task automatic req(input logic we, input int idx, input int off,
                     input logic [63:0] wd, input logic [7:0] st);
    logic ok;
    ok = 1'b0;
    req_valid = 1'b1; req_we = we; req_idx = IDX_W'(idx); req_off = OFF_W'(off);
    req_wdata = wd; req_wstrb = st;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk); ok = req_ready;
      @(posedge clk); #1;
    end
    if (!ok) chk("req_accept_timeout", 64'd0, 64'd1);
    req_valid = 1'b0; req_we = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    chk("reset_rsp_rdata", rsp_rdata, 64'd0);
    chk("reset_fill_err", {63'd0, fill_err}, 64'd0);
    rst_n = 1'b1;
    cyc();

    // Refill line 5 and read it back.
    beat(5, 64'h1111, 1'b0);
    beat(5, 64'h2222, 1'b1);
    chk("t1_done", {63'd0, fill_done}, 64'd1);
    chk("t1_err", {63'd0, fill_err}, 64'd0);
    req(1'b0, 5, 0, '0, '0);
    chk("t1_rv", {63'd0, rsp_valid}, 64'd1);
    chk("t1_rd0", rsp_rdata, 64'h1111);
    req(1'b0, 5, 1, '0, '0);
    chk("t1_rd1", rsp_rdata, 64'h2222);

    // Byte-masked write then immediate read.
    req(1'b1, 5, 0, 64'hAAAA_BBBB_CCCC_DDDD, 8'h0F);
    chk("t2_wr", rsp_rdata, 64'h0000_0000_CCCC_DDDD);
    req(1'b0, 5, 0, '0, '0);
    chk("t2_rd", rsp_rdata, 64'h0000_0000_CCCC_DDDD);
    req(1'b1, 5, 0, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00);
    chk("t2_nostrb", rsp_rdata, 64'h0000_0000_CCCC_DDDD);
    cyc();

    // Fill and request collide: fill wins, request waits.
    req_valid = 1'b1; req_we = 1'b0; req_idx = 5; req_off = 1;
    fill_valid = 1'b1; fill_idx = 9; fill_data = 64'h9090; fill_last = 1'b0;
    #1 chk("t3_rr0", {63'd0, req_ready}, 64'd0);
    cyc();
    fill_data = 64'h9191; fill_last = 1'b1;
    #1 chk("t3_rr1", {63'd0, req_ready}, 64'd0);
    cyc();
    fill_valid = 1'b0; fill_last = 1'b0;
    #1 chk("t3_rr2", {63'd0, req_ready}, 64'd1);
    cyc();
    req_valid = 1'b0;
    chk("t3_rv", {63'd0, rsp_valid}, 64'd1);
    chk("t3_rd", rsp_rdata, 64'h2222);
    cyc();

    // Early fill_last: error is sticky, line length still two beats.
    beat(7, 64'h7070, 1'b1);
    chk("t4_nodone", {63'd0, fill_done}, 64'd0);
    beat(7, 64'h7171, 1'b1);
    chk("t4_done", {63'd0, fill_done}, 64'd1);
    chk("t4_err", {63'd0, fill_err}, 64'd1);
    cyc(); cyc();
    chk("t4_err_sticky", {63'd0, fill_err}, 64'd1);
    req(1'b0, 7, 1, '0, '0);
    chk("t4_rd", rsp_rdata, 64'h7171);

    // Reset in the middle of a fill.
    beat(3, 64'h3333, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rv", {63'd0, rsp_valid}, 64'd0);
    chk("t5_rd", rsp_rdata, 64'd0);
    chk("t5_err", {63'd0, fill_err}, 64'd0);
    chk("t5_done", {63'd0, fill_done}, 64'd0);
    cyc(); cyc();
    rst_n = 1'b1;
    #1 chk("t5_rr", {63'd0, req_ready}, 64'd1);
    cyc();
    req(1'b0, 3, 0, '0, '0);
    chk("t5_keep", rsp_rdata, 64'h3333);
    beat(3, 64'h3030, 1'b0);
    beat(3, 64'h3131, 1'b1);
    req(1'b0, 3, 1, '0, '0);
    chk("t5_refill", rsp_rdata, 64'h3131);

    // Back-to-back reads, then a fill with a gap while a request is held off.
    for (int i = 0; i < 8; i++) begin
      req(1'b0, (i % 4 < 2) ? 5 : 9, i % 2, '0, '0);
    end
    chk("t6_last_rd", rsp_rdata, 64'h9191);
    cyc();
    req_valid = 1'b1; req_we = 1'b0; req_idx = 9; req_off = 0;
    fill_valid = 1'b1; fill_idx = 9; fill_data = 64'hA0A0; fill_last = 1'b0;
    cyc();
    fill_valid = 1'b0; fill_idx = 0;
    cyc(); cyc(); cyc();
    chk("t6_hold", rsp_rdata, 64'h9191);
    fill_valid = 1'b1; fill_data = 64'hA1A1; fill_last = 1'b1;
    cyc();
    fill_valid = 1'b0; fill_last = 1'b0;
    chk("t6_done", {63'd0, fill_done}, 64'd1);
    cyc();
    req_valid = 1'b0;
    chk("t6_rd0", rsp_rdata, 64'hA0A0);
    req(1'b0, 9, 1, '0, '0);
    chk("t6_rd1", rsp_rdata, 64'hA1A1);
    cyc(); cyc();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
